// File: rtl/operand_fetch.sv
// Operand fetch stage: S1 holds effective read addresses, S2 holds the
// forwarded, swizzled and negated operands behind a valid/ready handshake.
`ifndef DATA_ADDRESS_WIDTH
`define DATA_ADDRESS_WIDTH 8
`endif

module operand_fetch #(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 3 * WIDTH,
  parameter int ADDR_WIDTH = `DATA_ADDRESS_WIDTH,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iInstValid,
  output logic                  oInstReady,
  input  logic [ADDR_WIDTH-1:0] iSrc0Address,
  input  logic [ADDR_WIDTH-1:0] iSrc1Address,
  input  logic [1:0]            iSrc0Mode,
  input  logic [1:0]            iSrc1Mode,
  input  logic [5:0]            iSrc0Swizzle,
  input  logic [5:0]            iSrc1Swizzle,
  input  logic [2:0]            iSrc0Negate,
  input  logic [2:0]            iSrc1Negate,
  input  logic [TAG_WIDTH-1:0]  iTag,
  input  logic [ADDR_WIDTH-1:0] iFrameOffset,
  input  logic [ADDR_WIDTH-1:0] iIndexRegister,
  output logic [ADDR_WIDTH-1:0] oReadAddress0,
  output logic [ADDR_WIDTH-1:0] oReadAddress1,
  input  logic [DATA_WIDTH-1:0] iReadData0,
  input  logic [DATA_WIDTH-1:0] iReadData1,
  input  logic [2:0]            iWbEnable,
  input  logic [ADDR_WIDTH-1:0] iWbAddress,
  input  logic [DATA_WIDTH-1:0] iWbData,
  output logic                  oOperandValid,
  input  logic                  iOperandReady,
  output logic [DATA_WIDTH-1:0] oOperand0,
  output logic [DATA_WIDTH-1:0] oOperand1,
  output logic [TAG_WIDTH-1:0]  oTag
);

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr0_q, s1_addr0_d;
  logic [ADDR_WIDTH-1:0] s1_addr1_q, s1_addr1_d;
  logic [5:0]            s1_swz0_q, s1_swz0_d;
  logic [5:0]            s1_swz1_q, s1_swz1_d;
  logic [2:0]            s1_neg0_q, s1_neg0_d;
  logic [2:0]            s1_neg1_q, s1_neg1_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_op0_q, s2_op0_d;
  logic [DATA_WIDTH-1:0] s2_op1_q, s2_op1_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;

  logic advance;
  logic accept;

  function automatic logic [ADDR_WIDTH-1:0] eff_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [1:0]            mode,
    input logic [ADDR_WIDTH-1:0] frame,
    input logic [ADDR_WIDTH-1:0] index
  );
    logic [ADDR_WIDTH-1:0] a;
    unique case (mode)
      2'b01:   a = base + frame;
      2'b10:   a = base + frame + index;
      default: a = base;
    endcase
    return a;
  endfunction

  // Per-channel write forwarding, then swizzle, then sign flip.
  function automatic logic [DATA_WIDTH-1:0] shape_row(
    input logic [DATA_WIDTH-1:0] rd,
    input logic [2:0]            wb_en,
    input logic [ADDR_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0] wb_data,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [5:0]            swz,
    input logic [2:0]            neg
  );
    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] row;
    logic [WIDTH-1:0]      ch;
    raw = rd;
    row = '0;
    for (int c = 0; c < 3; c++) begin
      if (wb_en[c] && wb_addr == addr)
        raw[c*WIDTH +: WIDTH] = wb_data[c*WIDTH +: WIDTH];
    end
    for (int k = 0; k < 3; k++) begin
      unique case (swz[2*k +: 2])
        2'b00:   ch = raw[2*WIDTH +: WIDTH];
        2'b01:   ch = raw[WIDTH +: WIDTH];
        2'b10:   ch = raw[0 +: WIDTH];
        default: ch = '0;
      endcase
      ch[WIDTH-1] = ch[WIDTH-1] ^ neg[k];
      row[k*WIDTH +: WIDTH] = ch;
    end
    return row;
  endfunction

  assign advance    = s1_valid_q & (~s2_valid_q | iOperandReady);
  assign oInstReady = ~s1_valid_q | advance;
  assign accept     = iInstValid & oInstReady;

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~advance);
    s1_addr0_d = s1_addr0_q;
    s1_addr1_d = s1_addr1_q;
    s1_swz0_d  = s1_swz0_q;
    s1_swz1_d  = s1_swz1_q;
    s1_neg0_d  = s1_neg0_q;
    s1_neg1_d  = s1_neg1_q;
    s1_tag_d   = s1_tag_q;
    if (accept) begin
      s1_addr0_d = eff_addr(iSrc0Address, iSrc0Mode,
                            iFrameOffset, iIndexRegister);
      s1_addr1_d = eff_addr(iSrc1Address, iSrc1Mode,
                            iFrameOffset, iIndexRegister);
      s1_swz0_d  = iSrc0Swizzle;
      s1_swz1_d  = iSrc1Swizzle;
      s1_neg0_d  = iSrc0Negate;
      s1_neg1_d  = iSrc1Negate;
      s1_tag_d   = iTag;
    end
  end

  always_comb begin
    s2_valid_d = advance | (s2_valid_q & ~iOperandReady);
    s2_op0_d   = s2_op0_q;
    s2_op1_d   = s2_op1_q;
    s2_tag_d   = s2_tag_q;
    if (advance) begin
      s2_op0_d = shape_row(iReadData0, iWbEnable, iWbAddress, iWbData,
                           s1_addr0_q, s1_swz0_q, s1_neg0_q);
      s2_op1_d = shape_row(iReadData1, iWbEnable, iWbAddress, iWbData,
                           s1_addr1_q, s1_swz1_q, s1_neg1_q);
      s2_tag_d = s1_tag_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_addr0_q <= '0;
      s1_addr1_q <= '0;
      s1_swz0_q  <= '0;
      s1_swz1_q  <= '0;
      s1_neg0_q  <= '0;
      s1_neg1_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_op0_q   <= '0;
      s2_op1_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr0_q <= s1_addr0_d;
      s1_addr1_q <= s1_addr1_d;
      s1_swz0_q  <= s1_swz0_d;
      s1_swz1_q  <= s1_swz1_d;
      s1_neg0_q  <= s1_neg0_d;
      s1_neg1_q  <= s1_neg1_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_op0_q   <= s2_op0_d;
      s2_op1_q   <= s2_op1_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign oReadAddress0 = s1_addr0_q;
  assign oReadAddress1 = s1_addr1_q;
  assign oOperandValid = s2_valid_q;
  assign oOperand0     = s2_op0_q;
  assign oOperand1     = s2_op1_q;
  assign oTag          = s2_tag_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: queue-level reference model with a register
// file array, directed scenarios and randomized traffic.
`timescale 1ns/1ps

module tb_operand_fetch;

  localparam int W  = 32;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int TW = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iInstValid;
  logic          oInstReady;
  logic [AW-1:0] iSrc0Address, iSrc1Address;
  logic [1:0]    iSrc0Mode, iSrc1Mode;
  logic [5:0]    iSrc0Swizzle, iSrc1Swizzle;
  logic [2:0]    iSrc0Negate, iSrc1Negate;
  logic [TW-1:0] iTag;
  logic [AW-1:0] iFrameOffset, iIndexRegister;
  logic [AW-1:0] oReadAddress0, oReadAddress1;
  logic [DW-1:0] iReadData0, iReadData1;
  logic [2:0]    iWbEnable;
  logic [AW-1:0] iWbAddress;
  logic [DW-1:0] iWbData;
  logic          oOperandValid;
  logic          iOperandReady;
  logic [DW-1:0] oOperand0, oOperand1;
  logic [TW-1:0] oTag;

  operand_fetch #(
    .WIDTH(W), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iInstValid(iInstValid), .oInstReady(oInstReady),
    .iSrc0Address(iSrc0Address), .iSrc1Address(iSrc1Address),
    .iSrc0Mode(iSrc0Mode), .iSrc1Mode(iSrc1Mode),
    .iSrc0Swizzle(iSrc0Swizzle), .iSrc1Swizzle(iSrc1Swizzle),
    .iSrc0Negate(iSrc0Negate), .iSrc1Negate(iSrc1Negate),
    .iTag(iTag),
    .iFrameOffset(iFrameOffset), .iIndexRegister(iIndexRegister),
    .oReadAddress0(oReadAddress0), .oReadAddress1(oReadAddress1),
    .iReadData0(iReadData0), .iReadData1(iReadData1),
    .iWbEnable(iWbEnable), .iWbAddress(iWbAddress), .iWbData(iWbData),
    .oOperandValid(oOperandValid), .iOperandReady(iOperandReady),
    .oOperand0(oOperand0), .oOperand1(oOperand1), .oTag(oTag)
  );

  always #5 Clock = ~Clock;

  logic [DW-1:0] rf [256];
  assign iReadData0 = rf[oReadAddress0];
  assign iReadData1 = rf[oReadAddress1];

  typedef struct {
    logic [AW-1:0] a0, a1;
    logic [5:0]    s0, s1;
    logic [2:0]    n0, n1;
    logic [TW-1:0] tag;
    bit            done;
    logic [DW-1:0] v0, v1;
  } item_t;

  item_t         q[$];
  logic [AW-1:0] last_a0, last_a1;
  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] got_tags[$];

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ea(logic [AW-1:0] b, logic [1:0] m,
                                       logic [AW-1:0] f, logic [AW-1:0] x);
    int s;
    s = int'(b);
    if (m == 2'd1) s = s + int'(f);
    if (m == 2'd2) s = s + int'(f) + int'(x);
    return AW'(s % 256);
  endfunction

  // Channels listed X,Y,Z; codes 0..2 pick from that list, 3 gives zero.
  function automatic logic [DW-1:0] xform(logic [DW-1:0] row,
                                          logic [5:0] swz, logic [2:0] neg);
    logic [W-1:0] c[3];
    logic [W-1:0] v;
    logic [1:0]   sel;
    logic [DW-1:0] o;
    c[0] = row[95:64];
    c[1] = row[63:32];
    c[2] = row[31:0];
    o = '0;
    for (int k = 0; k < 3; k++) begin
      sel = swz[5-2*k -: 2];
      v = (sel == 2'd3) ? '0 : c[sel];
      if (neg[2-k]) v[W-1] = ~v[W-1];
      o[95-32*k -: 32] = v;
    end
    return o;
  endfunction

  task automatic idle();
    iInstValid = 0;
    iSrc0Address = 0; iSrc1Address = 0;
    iSrc0Mode = 0; iSrc1Mode = 0;
    iSrc0Swizzle = 6'b00_01_10; iSrc1Swizzle = 6'b00_01_10;
    iSrc0Negate = 0; iSrc1Negate = 0;
    iTag = 0; iFrameOffset = 0; iIndexRegister = 0;
    iWbEnable = 0; iWbAddress = 0; iWbData = 0;
  endtask

  // Inputs must be settled; compares, then commits the model past the edge.
  task automatic step(output bit acc);
    bit s2f, s1f, adv, fire;
    int ui;
    #1;
    s2f  = q.size() > 0 && q[0].done;
    ui   = s2f ? 1 : 0;
    s1f  = q.size() > ui;
    fire = s2f && iOperandReady;
    adv  = s1f && (!s2f || iOperandReady);
    acc  = iInstValid && (!s1f || adv);
    check("inst_ready", DW'(oInstReady), DW'(!s1f || adv));
    check("op_valid", DW'(oOperandValid), DW'(s2f));
    check("read_addr0", DW'(oReadAddress0), DW'(last_a0));
    check("read_addr1", DW'(oReadAddress1), DW'(last_a1));
    if (s2f) begin
      check("operand0", oOperand0, q[0].v0);
      check("operand1", oOperand1, q[0].v1);
      check("tag", DW'(oTag), DW'(q[0].tag));
    end
    if (oOperandValid && iOperandReady) got_tags.push_back(oTag);
    @(posedge Clock);
    #1;
    for (int c = 0; c < 3; c++)
      if (iWbEnable[c]) rf[iWbAddress][32*c +: 32] = iWbData[32*c +: 32];
    if (adv) begin
      q[ui].v0 = xform(rf[q[ui].a0], q[ui].s0, q[ui].n0);
      q[ui].v1 = xform(rf[q[ui].a1], q[ui].s1, q[ui].n1);
      q[ui].done = 1;
    end
    if (fire) void'(q.pop_front());
    if (acc) begin
      item_t it;
      it.a0 = ea(iSrc0Address, iSrc0Mode, iFrameOffset, iIndexRegister);
      it.a1 = ea(iSrc1Address, iSrc1Mode, iFrameOffset, iIndexRegister);
      it.s0 = iSrc0Swizzle; it.s1 = iSrc1Swizzle;
      it.n0 = iSrc0Negate;  it.n1 = iSrc1Negate;
      it.tag = iTag; it.done = 0; it.v0 = '0; it.v1 = '0;
      q.push_back(it);
      last_a0 = it.a0;
      last_a1 = it.a1;
    end
  endtask

  task automatic cyc();
    bit a;
    step(a);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1;
    #1;
    check("rst_valid", DW'(oOperandValid), DW'(0));
    check("rst_ready", DW'(oInstReady), DW'(1));
    check("rst_op0", oOperand0, '0);
    check("rst_op1", oOperand1, '0);
    check("rst_tag", DW'(oTag), DW'(0));
    check("rst_addr0", DW'(oReadAddress0), DW'(0));
    q.delete();
    last_a0 = 0;
    last_a1 = 0;
    @(negedge Clock);
    Reset = 0;
  endtask

  initial begin
    bit a;
    int k;
    for (int i = 0; i < 256; i++)
      rf[i] = {$urandom, $urandom, $urandom};
    idle();
    iOperandReady = 1;
    Reset = 0;
    @(negedge Clock);
    do_reset();

    // Absolute read with identity swizzle
    rf[8'h10] = {32'd1, 32'd2, 32'd3};
    iInstValid = 1; iSrc0Address = 8'h10; iTag = 8'h01;
    cyc();
    idle();
    step(a);
    check("t1_valid", DW'(oOperandValid), DW'(1));
    check("t1_op0", oOperand0, {32'd1, 32'd2, 32'd3});
    @(negedge Clock);
    cyc();

    // Indexed mode wraps modulo 256
    iInstValid = 1; iSrc0Address = 8'h05; iSrc0Mode = 2'b10;
    iFrameOffset = 8'hF0; iIndexRegister = 8'h20;
    step(a);
    check("t2_addr", DW'(oReadAddress0), DW'(8'h15));
    @(negedge Clock);
    idle();
    cyc(); cyc();

    // Swizzle and negate
    rf[8'h20] = {32'h3F800000, 32'h40000000, 32'h40400000};
    iInstValid = 1; iSrc0Address = 8'h20; iSrc1Address = 8'h20;
    iSrc0Swizzle = 6'b10_01_00; iSrc0Negate = 3'b001;
    iSrc1Swizzle = 6'b11_11_11;
    cyc();
    idle();
    step(a);
    check("t3_op0", oOperand0, {32'h40400000, 32'h40000000, 32'hBF800000});
    check("t3_op1", oOperand1, '0);
    @(negedge Clock);
    cyc();

    // Same-edge write is forwarded per channel
    iInstValid = 1; iSrc0Address = 8'h10;
    cyc();
    idle();
    iWbEnable = 3'b101; iWbAddress = 8'h10;
    iWbData = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    step(a);
    check("t4_op0", oOperand0, {32'hAAAA_0001, 32'd2, 32'hCCCC_0003});
    @(negedge Clock);
    idle();
    cyc(); cyc();

    // Backpressure: capacity two, then in-order delivery
    got_tags.delete();
    iOperandReady = 0;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      iInstValid = 1; iTag = TW'(k);
      step(a);
      if (a) k++;
      @(negedge Clock);
    end
    check("t5_stall_ready", DW'(oInstReady), DW'(0));
    check("t5_accepted", DW'(k), DW'(2));
    iOperandReady = 1;
    for (int c = 0; c < 12; c++) begin
      iInstValid = (k < 4); iTag = TW'(k);
      step(a);
      if (a) k++;
      @(negedge Clock);
    end
    idle();
    check("t5_count", DW'(got_tags.size()), DW'(4));
    for (int i = 0; i < 4 && i < got_tags.size(); i++)
      check("t5_order", DW'(got_tags[i]), DW'(i));

    // Reset with both stages full
    iOperandReady = 0;
    iInstValid = 1; iTag = 8'h55;
    cyc(); cyc();
    idle();
    check("t6_full", DW'(oInstReady), DW'(0));
    do_reset();
    got_tags.delete();
    iOperandReady = 1;
    iInstValid = 1; iTag = 8'h77;
    cyc();
    idle();
    cyc(); cyc();
    check("t6_first_tag", DW'(got_tags.size() > 0 ? got_tags[0] : 8'h00),
          DW'(8'h77));

    // Randomized traffic on a small address window
    for (int n = 0; n < 3000; n++) begin
      iInstValid     = $urandom_range(0, 3) != 0;
      iSrc0Address   = AW'($urandom_range(0, 15));
      iSrc1Address   = AW'($urandom_range(0, 15));
      iSrc0Mode      = 2'($urandom);
      iSrc1Mode      = 2'($urandom);
      iSrc0Swizzle   = 6'($urandom);
      iSrc1Swizzle   = 6'($urandom);
      iSrc0Negate    = 3'($urandom);
      iSrc1Negate    = 3'($urandom);
      iTag           = 8'($urandom);
      iFrameOffset   = ($urandom_range(0, 7) == 0) ? 8'hFC
                                                   : AW'($urandom_range(0, 3));
      iIndexRegister = AW'($urandom_range(0, 5));
      iWbEnable      = 3'($urandom);
      iWbAddress     = AW'($urandom_range(0, 15));
      iWbData        = {$urandom, $urandom, $urandom};
      iOperandReady  = $urandom_range(0, 2) != 0;
      if (n == 1500) begin
        do_reset();
      end
      step(a);
      @(negedge Clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
